snake_row_scanner: RTL and testbench
====================================

Name: snake_row_scanner

Overview:
Display-side reader of the snake node interface. At the start of each grid row it sweeps the node index, reads back each node's cell coordinates, and builds a 40-bit occupancy mask for that row, plus the head column. Masks are double-buffered, so the pixel path sees a stable row while the next row is scanned. It sits between the snake controller (which supplies node_cube_x/y for a given node) and the VGA colour mux.

Parameters:
GRID_W, 40, grid columns; this is the mask width, and x >= GRID_W is ignored.
MAX_NODES, 16, node slots exposed by the controller.
BASE_LEN, 3, nodes always present; live nodes = BASE_LEN + cubenum, capped at MAX_NODES.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
row_start  in  1  one-cycle pulse during h-blank; requests a scan of row_y
row_y  in  6  grid row to scan, sampled with row_start
cubenum  in  4  apples eaten (15 = game-over/full), sampled with row_start
node  out  4  node index driven to the controller
node_cube_x  in  6  x of the indexed node; combinational from node, same cycle
node_cube_y  in  6  y of the indexed node
pix_col  in  6  grid column currently being drawn
body_hit  out  1  registered; active-mask bit at pix_col
head_hit  out  1  registered; pix_col equals the active head column and the head is in the active row
busy  out  1  high in SCAN or COMMIT
done  out  1  one-cycle pulse when the new active mask becomes visible

Behaviour:
- Reset values (async, immediate): state IDLE, node=0, shadow and active masks =0, head_valid=0, head_col=0, body_hit=0, head_hit=0, busy=0, done=0.
- The FSM has three states: IDLE, SCAN and COMMIT.
- IDLE:
  - node is held at 0.
  - When row_start=1, latch row_y into ry and last = min(cubenum+BASE_LEN-1, MAX_NODES-1).
  - Clear the shadow mask and shadow head, set idx=0, and go to SCAN.
- SCAN:
  - node=idx. At each edge, if node_cube_y==ry and node_cube_x<GRID_W, set shadow[node_cube_x].
  - If idx==0 and the same match holds, set shadow_head_valid=1 and shadow_head_col=node_cube_x.
  - If idx==last, go to COMMIT; otherwise idx increments.
  - Exactly last+1 SCAN cycles.
- COMMIT (one cycle):
  - At the exit edge, copy shadow mask and head to the active registers, pulse done for the following cycle, and return to IDLE.
- Latency: row_start sampled at edge E0 gives SCAN cycles E0..E(last+1) and COMMIT E(last+1)..E(last+2). The active mask and done are visible after E(last+2).
  - Initial snake (last=2): 4 edges.
  - Full snake (last=15): 17 edges.
- row_start during SCAN or COMMIT:
  - The scan restarts: new ry and last are latched, shadow is cleared, idx=0, state SCAN.
  - The active mask is not updated by the aborted scan.
  - If row_start coincides with the COMMIT exit edge, the commit still completes (done pulses) and the new scan starts.
- Duplicate coordinates (self-collision) set the same bit; this is harmless.
- Nodes beyond last are never indexed, so the zeroed tail slots at (0,0) are never drawn.
- Pixel path (every cycle, independent of state):
  - body_hit <= (pix_col<GRID_W) & active[pix_col].
  - head_hit <= head_valid & (pix_col==head_col).
  - Latency is 1 cycle.
  - pix_col>=GRID_W gives 0 on both outputs.
- Widths: idx is 4 bits. The last computation uses 5-bit arithmetic before the cap, so cubenum=15 gives 17 → capped to 15, with no wrap.
- Reset mid-scan aborts immediately: masks are cleared and node=0.

Test Plan:
- Reset, then cubenum=0 and controller nodes (20,15),(20,14),(20,13); row_start with row_y=15 → node sequence 0,1,2; done 4 edges after the pulse; active mask = bit20 only; pix_col=20 gives body_hit=1 and head_hit=1 one cycle later.
- Same snake, row_y=14 → mask bit20, head_hit=0 at col 20. row_y=16 → mask all zero, done still pulses.
- cubenum=15 with nodes 0..15 at (0..15, 7) → node counts 0..15; done after 17 edges; mask bits 0..15 set; head_col=0.
- Horizontal snake at y=5 scanned for row 5 (done). Then row_start for row 6 with a second row_start at SCAN cycle 2 for row 5 → the active mask stays at the row-5 pattern until the restarted scan commits; exactly one done pulse is produced.
- Node with x=45, y=ry → ignored; pix_col=45 gives body_hit=0.
- Assert rst_n low during SCAN → node=0, busy=0, masks zero immediately; a fresh row_start after release scans normally.

Source files
------------

// File: rtl/snake_row_scanner.sv
// snake_row_scanner: per-row occupancy scanner for the snake display path.
// On each row_start it sweeps the live node slots, builds a GRID_W-bit mask
// of the cells on row_y (plus the head column) in a shadow buffer, then
// commits it to the active buffer that feeds the pixel lookup.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   row_start, row_y  scan request pulse and grid row to scan
//   cubenum           apples eaten; sets the number of live nodes
//   node              node index presented to the snake controller
//   node_cube_x/y     coordinates of the indexed node (same cycle)
//   pix_col           grid column being drawn
//   body_hit/head_hit registered pixel hits against the active row
//   busy, done        scan in progress / new active row visible pulse
module snake_row_scanner #(
    parameter int unsigned GRID_W    = 40,
    parameter int unsigned MAX_NODES = 16,
    parameter int unsigned BASE_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       row_start,
    input  logic [5:0] row_y,
    input  logic [3:0] cubenum,
    output logic [3:0] node,
    input  logic [5:0] node_cube_x,
    input  logic [5:0] node_cube_y,
    input  logic [5:0] pix_col,
    output logic       body_hit,
    output logic       head_hit,
    output logic       busy,
    output logic       done
);

    localparam int unsigned IDX_W   = 4;
    localparam int unsigned COORD_W = 6;
    localparam int unsigned SUM_W   = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     node_d;
    logic [COORD_W-1:0]   ry_q, ry_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [GRID_W-1:0]    shadow_q, shadow_d;
    logic                 sh_hv_q, sh_hv_d;
    logic [COORD_W-1:0]   sh_hc_q, sh_hc_d;
    logic [GRID_W-1:0]    active_q, active_d;
    logic                 hv_q, hv_d;
    logic [COORD_W-1:0]   hc_q, hc_d;
    logic                 done_d;
    logic                 busy_d;

    logic [SUM_W-1:0]     len_sum_c;
    logic [IDX_W-1:0]     last_c;
    logic                 coord_hit_c;
    logic                 pix_in_c;

    // Last live node index; 5-bit sum so cubenum=15 saturates instead of wrapping.
    always_comb begin
        len_sum_c = SUM_W'(cubenum) + SUM_W'(BASE_LEN) - SUM_W'(1);
        if (len_sum_c > SUM_W'(MAX_NODES - 1))
            last_c = IDX_W'(MAX_NODES - 1);
        else
            last_c = len_sum_c[IDX_W-1:0];
    end

    assign coord_hit_c = (node_cube_y == ry_q) && (node_cube_x < COORD_W'(GRID_W));
    assign pix_in_c    = (pix_col < COORD_W'(GRID_W));

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        node_d   = node;
        ry_d     = ry_q;
        last_d   = last_q;
        shadow_d = shadow_q;
        sh_hv_d  = sh_hv_q;
        sh_hc_d  = sh_hc_q;
        active_d = active_q;
        hv_d     = hv_q;
        hc_d     = hc_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                node_d = '0;
            end
            SCAN: begin
                if (coord_hit_c) begin
                    shadow_d[node_cube_x] = 1'b1;
                    if (node == '0) begin
                        sh_hv_d = 1'b1;
                        sh_hc_d = node_cube_x;
                    end
                end
                if (node == last_q) begin
                    state_d = COMMIT;
                    node_d  = '0;
                end else begin
                    node_d = node + IDX_W'(1);
                end
            end
            COMMIT: begin
                active_d = shadow_q;
                hv_d     = sh_hv_q;
                hc_d     = sh_hc_q;
                done_d   = 1'b1;
                state_d  = IDLE;
                node_d   = '0;
            end
            default: begin
                state_d = IDLE;
                node_d  = '0;
            end
        endcase

        // A new request always (re)starts the scan; a coincident commit above still lands.
        if (row_start) begin
            state_d  = SCAN;
            ry_d     = row_y;
            last_d   = last_c;
            shadow_d = '0;
            sh_hv_d  = 1'b0;
            sh_hc_d  = '0;
            node_d   = '0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            node     <= '0;
            ry_q     <= '0;
            last_q   <= '0;
            shadow_q <= '0;
            sh_hv_q  <= 1'b0;
            sh_hc_q  <= '0;
            active_q <= '0;
            hv_q     <= 1'b0;
            hc_q     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            node     <= node_d;
            ry_q     <= ry_d;
            last_q   <= last_d;
            shadow_q <= shadow_d;
            sh_hv_q  <= sh_hv_d;
            sh_hc_q  <= sh_hc_d;
            active_q <= active_d;
            hv_q     <= hv_d;
            hc_q     <= hc_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Pixel lookup against the active row, one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            body_hit <= 1'b0;
            head_hit <= 1'b0;
        end else begin
            body_hit <= pix_in_c && active_q[pix_col];
            head_hit <= hv_q && (pix_col == hc_q);
        end
    end

endmodule

// File: tb/tb_snake_row_scanner.sv
// Scoreboard bench for snake_row_scanner: stimulus queues expected done
// latencies, node indices and pixel hits; a monitor pops and compares them
// as the DUT presents done, busy and registered pixel outputs.
module tb_snake_row_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       row_start = 1'b0;
    logic [5:0] row_y = '0;
    logic [3:0] cubenum = '0;
    logic [3:0] node;
    logic [5:0] node_cube_x;
    logic [5:0] node_cube_y;
    logic [5:0] pix_col = '0;
    logic       body_hit;
    logic       head_hit;
    logic       busy;
    logic       done;

    // Snake controller model: node slot coordinates.
    logic [5:0] nx [16];
    logic [5:0] ny [16];
    assign node_cube_x = nx[node];
    assign node_cube_y = ny[node];

    snake_row_scanner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_start  (row_start),
        .row_y      (row_y),
        .cubenum    (cubenum),
        .node       (node),
        .node_cube_x(node_cube_x),
        .node_cube_y(node_cube_y),
        .pix_col    (pix_col),
        .body_hit   (body_hit),
        .head_hit   (head_hit),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int start;
        int lat;
    } done_exp_t;

    done_exp_t  done_q[$];
    int         node_q[$];
    logic [1:0] pix_q[$];
    done_exp_t  mon_d;
    int         mon_n;
    logic [1:0] mon_p;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic pix_req = 1'b0;
    logic pix_pend = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pix_pend <= 1'b0;
        else        pix_pend <= pix_req;
    end

    // Monitor: compare DUT outputs against queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 64'(done), 64'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("done_latency", 64'(cyc - mon_d.start - 1), 64'(mon_d.lat));
                end
            end
            if (busy && node_q.size() > 0) begin
                mon_n = node_q.pop_front();
                chk("node_seq", 64'(node), 64'(mon_n));
            end
            if (pix_pend) begin
                if (pix_q.size() == 0) begin
                    chk("pix_unexpected", 64'(pix_pend), 64'd0);
                end else begin
                    mon_p = pix_q.pop_front();
                    chk("body_hit", 64'(body_hit), 64'(mon_p[1]));
                    chk("head_hit", 64'(head_hit), 64'(mon_p[0]));
                end
            end
        end
    end

    task automatic clear_nodes();
        for (int i = 0; i < 16; i++) begin
            nx[i] = '0;
            ny[i] = '0;
        end
    endtask

    // Issue a one-cycle row_start; last is the hand-computed last node index.
    task automatic start_scan(input logic [5:0] ry, input logic [3:0] cn, input int last,
                              input bit exp_done, input bit exp_nodes);
        done_exp_t d;
        @(negedge clk);
        row_start = 1'b1;
        row_y     = ry;
        cubenum   = cn;
        if (exp_done) begin
            d.start = cyc;
            d.lat   = last + 2;
            done_q.push_back(d);
        end
        if (exp_nodes) begin
            for (int i = 0; i <= last; i++) node_q.push_back(i);
            node_q.push_back(0);
        end
        @(negedge clk);
        row_start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (done_q.size() == 0 && node_q.size() == 0 && !busy) break;
        end
        chk("scan_drained", 64'(done_q.size() + node_q.size()), 64'd0);
        done_q.delete();
        node_q.delete();
    endtask

    task automatic pix(input logic [5:0] c, input bit eb, input bit eh);
        @(negedge clk);
        pix_req = 1'b1;
        pix_col = c;
        pix_q.push_back({eb, eh});
    endtask

    task automatic end_pix();
        @(negedge clk);
        pix_req = 1'b0;
        @(negedge clk);
        chk("pix_drained", 64'(pix_q.size()), 64'd0);
        pix_q.delete();
    endtask

    task automatic sweep(input logic [39:0] mask, input bit hv, input logic [5:0] hc);
        logic [5:0] c;
        for (int i = 0; i < 49; i++) begin
            c = (i == 48) ? 6'd63 : 6'(i);
            pix(c, (i < 40) ? mask[i] : 1'b0, hv && (c == hc));
        end
        end_pix();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_nodes();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_node", 64'(node), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_body", 64'(body_hit), 64'd0);
        chk("rst_head", 64'(head_hit), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Initial vertical snake, head at (20,15).
        nx[0] = 6'd20; ny[0] = 6'd15;
        nx[1] = 6'd20; ny[1] = 6'd14;
        nx[2] = 6'd20; ny[2] = 6'd13;
        start_scan(6'd15, 4'd0, 2, 1'b1, 1'b1);
        wait_idle();
        sweep(40'h00_0010_0000, 1'b1, 6'd20);

        start_scan(6'd14, 4'd0, 2, 1'b1, 1'b1);
        wait_idle();
        sweep(40'h00_0010_0000, 1'b0, 6'd0);

        start_scan(6'd16, 4'd0, 2, 1'b1, 1'b1);
        wait_idle();
        sweep(40'h0, 1'b0, 6'd0);

        // Tail slots at (0,0) are beyond last and must not draw.
        start_scan(6'd0, 4'd0, 2, 1'b1, 1'b1);
        wait_idle();
        sweep(40'h0, 1'b0, 6'd0);

        // Full snake: cubenum=15 saturates to last=15.
        for (int i = 0; i < 16; i++) begin
            nx[i] = 6'(i);
            ny[i] = 6'd7;
        end
        start_scan(6'd7, 4'd15, 15, 1'b1, 1'b1);
        wait_idle();
        sweep(40'h00_0000_FFFF, 1'b1, 6'd0);

        // Horizontal snake on row 5, head at 14, length 5.
        clear_nodes();
        for (int i = 0; i < 5; i++) begin
            nx[i] = 6'(14 - i);
            ny[i] = 6'd5;
        end
        start_scan(6'd5, 4'd2, 4, 1'b1, 1'b1);
        wait_idle();
        sweep(40'h00_0000_7C00, 1'b1, 6'd14);

        // Row 6 scan aborted at SCAN cycle 2 by a row 5 request; one done only.
        start_scan(6'd6, 4'd2, 4, 1'b0, 1'b0);
        start_scan(6'd5, 4'd2, 4, 1'b1, 1'b0);
        pix(6'd12, 1'b1, 1'b0);
        pix(6'd14, 1'b1, 1'b1);
        pix(6'd20, 1'b0, 1'b0);
        end_pix();
        wait_idle();
        sweep(40'h00_0000_7C00, 1'b1, 6'd14);

        // Off-grid head x=45 is ignored, including as head.
        clear_nodes();
        nx[0] = 6'd45; ny[0] = 6'd9;
        nx[1] = 6'd3;  ny[1] = 6'd9;
        nx[2] = 6'd4;  ny[2] = 6'd8;
        start_scan(6'd9, 4'd0, 2, 1'b1, 1'b1);
        wait_idle();
        sweep(40'h00_0000_0008, 1'b0, 6'd0);

        // Reset in the middle of a scan.
        pix(6'd3, 1'b1, 1'b0);
        end_pix();
        pix_col = 6'd3;
        start_scan(6'd9, 4'd0, 2, 1'b0, 1'b0);
        @(negedge clk);
        chk("mid_scan_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_node", 64'(node), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_body", 64'(body_hit), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pix(6'd3, 1'b0, 1'b0);
        end_pix();
        start_scan(6'd9, 4'd0, 2, 1'b1, 1'b1);
        wait_idle();
        sweep(40'h00_0000_0008, 1'b0, 6'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
